plru_replacement_engine: RTL and testbench

Sequential tree-PLRU replacement engine for the LLC. It owns per-set PLRU state and serves requests from the cache controller over a valid/ready interface. Request types are hit-update, allocate (return victim and mark it MRU), query (return victim with no update) and clear. It is the stateful counterpart of the combinational PLRU update/victim helper functions and uses the identical tree encoding.

---
 rtl/plru_replacement_engine.sv | 182 ++++++++++++++++++
 tb/tb_plru_replacement_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_replacement_engine.sv
// Sequential tree-PLRU replacement engine: per-set PLRU state behind a valid/ready request/response port.
// Optional PLRU_STATS_EN adds 32-bit hit/alloc/query counters (stat_hits, stat_allocs, stat_queries).
module plru_replacement_engine #(
  parameter int N_WAY  = 16,
  parameter int N_SETS = 64,
  localparam int WAY_W = $clog2(N_WAY),
  localparam int SET_W = $clog2(N_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WAY_W-1:0] rsp_way,
  output logic [1:0]       rsp_op
`ifdef PLRU_STATS_EN
  ,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_allocs,
  output logic [31:0]      stat_queries
`endif
);

  localparam int TREE_W = N_WAY - 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OP_HIT   = 2'd0;
  localparam logic [1:0] OP_ALLOC = 2'd1;
  localparam logic [1:0] OP_QUERY = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  if (N_WAY < 2 || (N_WAY & (N_WAY - 1)) != 0) begin : g_bad_way
    $fatal(1, "plru_replacement_engine: N_WAY must be a power of 2 and at least 2");
  end
  if (N_SETS < 1 || (N_SETS & (N_SETS - 1)) != 0) begin : g_bad_sets
    $fatal(1, "plru_replacement_engine: N_SETS must be a power of 2");
  end

  // Victim walk: follow the complement of each node bit from the root, MSB of the way first.
  function automatic logic [WAY_W-1:0] f_victim(input logic [TREE_W-1:0] t);
    logic [WAY_W-1:0] v;
    int               n;
    v = '0;
    n = 0;
    for (int i = WAY_W - 1; i >= 0; i--) begin
      v[i] = ~t[n[WAY_W-1:0]];
      n    = 2 * n + (v[i] ? 2 : 1);
    end
    return v;
  endfunction

  function automatic logic [TREE_W-1:0] f_touch(input logic [TREE_W-1:0] t,
                                                input logic [WAY_W-1:0]  w);
    logic [TREE_W-1:0] r;
    int                n;
    r = t;
    n = 0;
    for (int i = WAY_W - 1; i >= 0; i--) begin
      r[n[WAY_W-1:0]] = w[i];
      n               = 2 * n + (w[i] ? 2 : 1);
    end
    return r;
  endfunction

  logic [TREE_W-1:0] r_plru [N_SETS];
  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [SET_W-1:0]  r_set;
  logic [WAY_W-1:0]  r_way;
  logic [TREE_W-1:0] r_vec;
  logic [WAY_W-1:0]  r_rsp_way;
  logic [1:0]        r_rsp_op;

  logic [WAY_W-1:0]  w_victim;
  logic [TREE_W-1:0] w_upd_hit;
  logic [TREE_W-1:0] w_upd_alloc;
  logic              w_rsp_fire;

  assign w_victim    = f_victim(r_vec);
  assign w_upd_hit   = f_touch(r_vec, r_way);
  assign w_upd_alloc = f_touch(r_vec, w_victim);
  assign w_rsp_fire  = (r_state == S_RESP) && rsp_ready;

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_way   = r_rsp_way;
  assign rsp_op    = r_rsp_op;

  // One request in flight: READ captures the set vector, UPDATE writes it back, so no forwarding is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_set     <= '0;
      r_way     <= '0;
      r_vec     <= '0;
      r_rsp_way <= '0;
      r_rsp_op  <= '0;
      for (int s = 0; s < N_SETS; s++) begin
        r_plru[s] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_set   <= req_set;
            r_way   <= req_way;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_vec   <= r_plru[r_set];
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          case (r_op)
            OP_HIT: begin
              r_plru[r_set] <= w_upd_hit;
              r_rsp_way     <= r_way;
            end
            OP_ALLOC: begin
              r_plru[r_set] <= w_upd_alloc;
              r_rsp_way     <= w_victim;
            end
            OP_QUERY: begin
              r_rsp_way <= w_victim;
            end
            default: begin
              r_plru[r_set] <= '0;
              r_rsp_way     <= '0;
            end
          endcase
          r_rsp_op <= r_op;
          r_state  <= S_RESP;
        end
        default: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef PLRU_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_allocs;
  logic [31:0] r_stat_queries;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_hits    <= '0;
      r_stat_allocs  <= '0;
      r_stat_queries <= '0;
    end else if (w_rsp_fire) begin
      case (r_rsp_op)
        OP_HIT:   r_stat_hits    <= r_stat_hits + 32'd1;
        OP_ALLOC: r_stat_allocs  <= r_stat_allocs + 32'd1;
        OP_QUERY: r_stat_queries <= r_stat_queries + 32'd1;
        default:  ;
      endcase
    end
  end

  assign stat_hits    = r_stat_hits;
  assign stat_allocs  = r_stat_allocs;
  assign stat_queries = r_stat_queries;
`else
  logic w_unused;
  assign w_unused = w_rsp_fire;
`endif

endmodule

// File: tb/tb_plru_replacement_engine.sv
// Bench for plru_replacement_engine: directed scenarios plus randomized traffic against a tree model.
module tb_plru_replacement_engine;

  localparam int N_WAY  = 16;
  localparam int N_SETS = 64;
  localparam int WAY_W  = 4;
  localparam int SET_W  = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [SET_W-1:0] req_set = '0;
  logic [WAY_W-1:0] req_way = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WAY_W-1:0] rsp_way;
  logic [1:0]       rsp_op;
`ifdef PLRU_STATS_EN
  logic [31:0]      stat_hits;
  logic [31:0]      stat_allocs;
  logic [31:0]      stat_queries;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  plru_replacement_engine #(.N_WAY(N_WAY), .N_SETS(N_SETS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_set   (req_set),
    .req_way   (req_way),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_way   (rsp_way),
    .rsp_op    (rsp_op)
`ifdef PLRU_STATS_EN
    ,
    .stat_hits    (stat_hits),
    .stat_allocs  (stat_allocs),
    .stat_queries (stat_queries)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Reference model: one bit per heap-ordered tree node per set (node k has children 2k+1, 2k+2).
  bit m_tree [N_SETS][N_WAY-1];

  function automatic void m_clear_all();
    for (int s = 0; s < N_SETS; s++)
      for (int k = 0; k < N_WAY - 1; k++)
        m_tree[s][k] = 1'b0;
  endfunction

  function automatic int m_victim(int s);
    int n = 0;
    int v = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      int b = m_tree[s][n] ? 0 : 1;
      v = v * 2 + b;
      n = 2 * n + 1 + b;
    end
    return v;
  endfunction

  function automatic void m_touch(int s, int w);
    int n = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      int b = (w >> (WAY_W - 1 - lvl)) & 1;
      m_tree[s][n] = (b != 0);
      n = 2 * n + 1 + b;
    end
  endfunction

  function automatic int m_apply(int op, int s, int w);
    int v;
    case (op)
      0: begin m_touch(s, w); return w; end
      1: begin v = m_victim(s); m_touch(s, v); return v; end
      2: return m_victim(s);
      default: begin
        for (int k = 0; k < N_WAY - 1; k++) m_tree[s][k] = 1'b0;
        return 0;
      end
    endcase
  endfunction

  // driver tasks: all start and end at a negedge
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_clear_all();
  endtask

  task automatic do_req(input logic [1:0] op, input logic [SET_W-1:0] set,
                        input logic [WAY_W-1:0] way, output logic [WAY_W-1:0] way_o,
                        output logic [1:0] op_o, output int lat);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_set   = set;
    req_way   = way;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_set   = SET_W'($urandom_range(0, N_SETS - 1));
    req_way   = WAY_W'($urandom_range(0, N_WAY - 1));
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    way_o = rsp_way;
    op_o  = rsp_op;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid);
    else n_pass++;
    n_checks++;
    if (rsp_way !== 4'd0) $display("FAIL reset_rsp_way: got %0d want 0", rsp_way);
    else n_pass++;
    n_checks++;
    if (rsp_op !== 2'd0) $display("FAIL reset_rsp_op: got %0d want 0", rsp_op);
    else n_pass++;
  endtask

  task automatic test_alloc_seq();
    int exp_way [3] = '{15, 7, 11};
    logic [WAY_W-1:0] w;
    logic [1:0] o;
    int lat;
    for (int i = 0; i < 3; i++) begin
      void'(m_apply(1, 0, 0));
      do_req(2'd1, 6'd0, 4'd0, w, o, lat);
      n_checks++;
      if (w !== WAY_W'(exp_way[i])) $display("FAIL alloc_seq_way[%0d]: got %0d want %0d", i, w, exp_way[i]);
      else n_pass++;
      n_checks++;
      if (o !== 2'd1) $display("FAIL alloc_seq_op[%0d]: got %0d want 1", i, o);
      else n_pass++;
      n_checks++;
      if (lat != 3) $display("FAIL alloc_seq_latency[%0d]: got %0d want 3", i, lat);
      else n_pass++;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL alloc_seq_ready_t4[%0d]: got %0b want 1", i, req_ready);
      else n_pass++;
    end
  endtask

  task automatic test_hit_query();
    logic [1:0] ops [5] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd2};
    int ways [5] = '{3, 0, 15, 0, 0};
    int exp_way [5] = '{3, 15, 15, 7, 7};
    logic [WAY_W-1:0] w;
    logic [1:0] o;
    int lat;
    for (int i = 0; i < 5; i++) begin
      void'(m_apply(int'(ops[i]), 5, ways[i]));
      do_req(ops[i], 6'd5, WAY_W'(ways[i]), w, o, lat);
      n_checks++;
      if (w !== WAY_W'(exp_way[i]) || o !== ops[i])
        $display("FAIL hit_query[%0d]: got way %0d op %0d want way %0d op %0d", i, w, o, exp_way[i], ops[i]);
      else n_pass++;
    end
  endtask

  task automatic test_isolation();
    logic [1:0] ops [5] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [SET_W-1:0] sets [5] = '{6'd0, 6'd0, 6'd1, 6'd0, 6'd0};
    int exp_way [5] = '{15, 7, 15, 0, 15};
    logic [WAY_W-1:0] w;
    logic [1:0] o;
    int lat;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      void'(m_apply(int'(ops[i]), int'(sets[i]), 0));
      do_req(ops[i], sets[i], 4'd0, w, o, lat);
      n_checks++;
      if (w !== WAY_W'(exp_way[i]) || o !== ops[i])
        $display("FAIL isolation[%0d]: got way %0d op %0d want way %0d op %0d", i, w, o, exp_way[i], ops[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [WAY_W-1:0] w;
    logic [1:0] o;
    int lat;
    int guard = 0;
    void'(m_apply(1, 3, 0));
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_set   = 6'd3;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid = 1'b1;
        req_op    = 2'd3;
        req_set   = 6'd3;
      end else begin
        req_valid = 1'b0;
      end
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_way !== 4'd15 || rsp_op !== 2'd1 || req_ready !== 1'b0)
        $display("FAIL backpressure_hold[%0d]: got valid %0b way %0d op %0d ready %0b want 1 15 1 0",
                 c, rsp_valid, rsp_way, rsp_op, req_ready);
      else n_pass++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL backpressure_no_extra[%0d]: got %0b want 0", c, rsp_valid);
      else n_pass++;
      @(negedge clk);
    end
    // The ignored CLEAR must leave set 3 holding the ALLOC update (next victim 7).
    do_req(2'd2, 6'd3, 4'd0, w, o, lat);
    n_checks++;
    if (w !== WAY_W'(m_apply(2, 3, 0))) $display("FAIL backpressure_state: got %0d want %0d", w, m_victim(3));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [WAY_W-1:0] w;
    logic [1:0] o;
    int lat;
    void'(m_apply(1, 2, 0));
    do_req(2'd1, 6'd2, 4'd0, w, o, lat);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_set   = 6'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_mid_rsp_valid: got %0b want 0", rsp_valid);
    else n_pass++;
    rst_n = 1'b1;
    m_clear_all();
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_mid_req_ready: got %0b want 1", req_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_mid_no_rsp: got %0b want 0", rsp_valid);
    else n_pass++;
    do_req(2'd2, 6'd2, 4'd0, w, o, lat);
    n_checks++;
    if (w !== 4'd15) $display("FAIL reset_mid_query: got %0d want 15", w);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [WAY_W-1:0] w;
    logic [1:0] o;
    int lat, op, s, way, e;
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      op  = $urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3;
      s   = $urandom_range(0, 3);
      way = $urandom_range(0, N_WAY - 1);
      e   = m_apply(op, s, way);
      do_req(2'(op), SET_W'(s), WAY_W'(way), w, o, lat);
      n_checks++;
      if (w !== WAY_W'(e) || o !== 2'(op) || lat != 3) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got way %0d op %0d lat %0d want way %0d op %0d lat 3",
                   i, w, o, lat, e, op);
        errs++;
      end else n_pass++;
    end
  endtask

`ifdef PLRU_STATS_EN
  task automatic test_stats();
    logic [1:0] ops [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [WAY_W-1:0] w;
    logic [1:0] o;
    int lat;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      void'(m_apply(int'(ops[i]), 9, i));
      do_req(ops[i], 6'd9, WAY_W'(i), w, o, lat);
    end
    n_checks++;
    if (stat_hits !== 32'd2 || stat_allocs !== 32'd3 || stat_queries !== 32'd1)
      $display("FAIL stats_count: got %0d %0d %0d want 2 3 1", stat_hits, stat_allocs, stat_queries);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (stat_hits !== 32'd0 || stat_allocs !== 32'd0 || stat_queries !== 32'd0)
      $display("FAIL stats_reset: got %0d %0d %0d want 0 0 0", stat_hits, stat_allocs, stat_queries);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_alloc_seq();
    test_hit_query();
    test_isolation();
    test_backpressure();
    test_reset_mid();
    do_reset();
    test_random();
`ifdef PLRU_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
